fetch_unit: RTL and testbench

- Instruction fetch front end; the producer side of the instruction decode interface.
- Generates the PC and issues requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions and presents them to the decode stage as instruction, PC and pre-split opcode/func3/func7 under a valid/ready handshake.
- Accepts redirects from execute (taken branch, JAL, JALR) and squashes all wrong-path fetches.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 50 +++++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end: instruction field positions,
// the NOP encoding, fetch FSM states and the buffered {pc, instr} entry.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;
   localparam int F7_LSB  = 25;
   localparam int F7_MSB  = 31;

   typedef enum logic [1:0] {
      START,
      RUN,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory request/response channels plus the
// decode handshake. The fetch unit is the master; memory/decode are the slave.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic [6:0]      dec_opcode;
   logic [2:0]      dec_func3;
   logic [6:0]      dec_func7;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output dec_valid,
      input  dec_ready,
      output dec_instr,
      output dec_pc,
      output dec_opcode,
      output dec_func3,
      output dec_func7
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  dec_valid,
      output dec_ready,
      input  dec_instr,
      input  dec_pc,
      input  dec_opcode,
      input  dec_func3,
      input  dec_func7
   );

endinterface

// File: rtl/fetch_fifo.sv
// Circular FIFO with flush and occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset: the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches under a credit limit,
// buffers returned instructions for decode and squashes wrong-path fetches.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_if.master    bus,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   drop_cnt_next;
   logic [CW-1:0]   owed;
   logic [CW-1:0]   buf_count;
   logic [CW-1:0]   pcq_count;
   logic            req_valid;
   logic            req_fire;
   logic            rsp_fire;
   logic            buf_push;
   logic            buf_pop;
   logic            buf_empty;
   fetch_entry_t    rsp_entry;
   fetch_entry_t    head;
   logic [XLEN-1:0] head_instr;
   logic [XLEN-1:0] head_pc;

   // Credit rule: outstanding plus buffered never exceeds the buffer depth,
   // so every response always has a slot waiting for it.
   assign req_valid       = (state == RUN) && ((int'(inflight) + int'(buf_count)) < BUF_DEPTH);
   assign req_fire        = req_valid && bus.imem_req_ready;
   assign rsp_fire        = bus.imem_rsp_valid;
   assign redirect_target = redirect_pc & ~XLEN'(3);
   assign owed            = inflight + CW'(req_fire) - CW'(rsp_fire);
   assign buf_empty       = (buf_count == '0);
   assign buf_push        = rsp_fire && (drop_cnt == '0) && !redirect_valid;
   assign buf_pop         = !buf_empty && bus.dec_ready;
   assign rsp_entry       = '{pc: rsp_pc, instr: bus.imem_rsp_data};

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (XLEN)
   ) u_pc_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (req_fire),
      .pop   (rsp_fire),
      .wdata (fetch_pc),
      .rdata (rsp_pc),
      .count (pcq_count)
   );

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_instr_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (buf_push),
      .pop   (buf_pop),
      .wdata (rsp_entry),
      .rdata (head),
      .count (buf_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= START;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         inflight <= inflight_next;
         drop_cnt <= drop_cnt_next;
      end
   end

   // A redirect turns every response still owed, including one accepted or
   // arriving in this very cycle, into a drop; the PC queue stays in step.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      inflight_next = owed;
      drop_cnt_next = drop_cnt;
      if (redirect_valid) begin
         fetch_pc_next = redirect_target;
         drop_cnt_next = owed;
         state_next    = (owed != '0) ? DRAIN : RUN;
      end else begin
         if (req_fire) fetch_pc_next = fetch_pc + XLEN'(4);
         if (rsp_fire && (drop_cnt != '0)) drop_cnt_next = drop_cnt - CW'(1);
         case (state)
            START:   state_next = RUN;
            RUN:     state_next = RUN;
            DRAIN:   state_next = (drop_cnt_next == '0) ? RUN : DRAIN;
            default: state_next = START;
         endcase
      end
   end

   assign head_instr = buf_empty ? NOP_INSTR : head.instr;
   assign head_pc    = buf_empty ? RESET_PC  : head.pc;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.dec_valid      = !buf_empty;
   assign bus.dec_instr      = head_instr;
   assign bus.dec_pc         = head_pc;
   assign bus.dec_opcode     = head_instr[OPC_MSB:OPC_LSB];
   assign bus.dec_func3      = head_instr[F3_MSB:F3_LSB];
   assign bus.dec_func7      = head_instr[F7_MSB:F7_LSB];

   assert property (@(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> (inflight != '0));
   assert property (@(posedge clk) disable iff (rst) inflight == pcq_count);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with fixed latency,
// a decode-side log, and hand-computed expected PCs and instruction fields.
module tb_fetch_unit;
   import riscv_pkg::*;

   typedef struct {
      logic        ready;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int          errors;
   int          checks;
   int          cycle;
   int          lat;
   logic [31:0] reqs[$];
   logic [31:0] seen_pc[$];
   logic [31:0] seen_instr[$];
   pend_t       pend[$];
   vec_t        vecs[3];

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Memory image: address 0 holds addi x1,x0,5; elsewhere func7/func3 encode the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[8:2], 5'd1, 5'd2, a[4:2], 5'd3, 7'h33};
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One clock: sample handshakes before the edge, then update the memory model.
   task automatic step();
      logic        acc;
      logic [31:0] addr;
      #1;
      acc  = bus.imem_req_valid && bus.imem_req_ready;
      addr = bus.imem_req_addr;
      if (bus.dec_valid && bus.dec_ready) begin
         seen_pc.push_back(bus.dec_pc);
         seen_instr.push_back(bus.dec_instr);
      end
      @(posedge clk);
      #1;
      cycle++;
      redirect_valid = 1'b0;
      if (acc) begin
         reqs.push_back(addr);
         pend.push_back('{addr: addr, due: cycle - 1 + lat});
      end
      if (pend.size() > 0 && pend[0].due <= cycle) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic resetDut(input int latency, input bit check_vals);
      rst                = 1'b1;
      redirect_valid     = 1'b0;
      redirect_pc        = 32'h0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.dec_ready      = 1'b1;
      lat                = latency;
      pend.delete();
      reqs.delete();
      seen_pc.delete();
      seen_instr.delete();
      #1;
      if (check_vals) begin
         checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
         checkOutput("rst_req_addr",  bus.imem_req_addr,       32'h0);
         checkOutput("rst_dec_valid", 32'(bus.dec_valid),      32'd0);
         checkOutput("rst_dec_instr", bus.dec_instr,           32'h0000_0013);
         checkOutput("rst_dec_pc",    bus.dec_pc,              32'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic waitReqs(input int n, input int budget, input string name);
      for (int i = 0; i < budget && reqs.size() < n; i++) step();
      checkOutput(name, 32'(reqs.size() >= n), 32'd1);
   endtask

   task automatic waitSeen(input int n, input int budget, input string name);
      for (int i = 0; i < budget && seen_pc.size() < n; i++) step();
      checkOutput(name, 32'(seen_pc.size() >= n), 32'd1);
   endtask

   // Wait for a head entry, compare every decode field, then let it be consumed.
   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      bus.dec_ready = v.ready;
      for (int i = 0; i < 20 && !bus.dec_valid; i++) step();
      checkOutput({tag, "_valid"},  32'(bus.dec_valid),  32'd1);
      checkOutput({tag, "_pc"},     bus.dec_pc,          v.pc);
      checkOutput({tag, "_instr"},  bus.dec_instr,       v.instr);
      checkOutput({tag, "_opcode"}, 32'(bus.dec_opcode), 32'(v.opcode));
      checkOutput({tag, "_func3"},  32'(bus.dec_func3),  32'(v.func3));
      checkOutput({tag, "_func7"},  32'(bus.dec_func7),  32'(v.func7));
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cycle  = 0;
      lat    = 1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.dec_ready      = 1'b1;

      vecs[0] = '{1'b1, 32'h0000_0000, 32'h0050_0093, 7'h13, 3'h0, 7'h00};
      vecs[1] = '{1'b1, 32'h0000_0004, 32'h0211_11B3, 7'h33, 3'h1, 7'h01};
      vecs[2] = '{1'b1, 32'h0000_0008, 32'h0411_21B3, 7'h33, 3'h2, 7'h02};

      #2;
      $display("[TB] streaming fetch, latency 1");
      resetDut(1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);
      waitReqs(3, 10, "t1_req_wait");
      checkOutput("t1_req0", qat(reqs, 0), 32'h0);
      checkOutput("t1_req1", qat(reqs, 1), 32'h4);
      checkOutput("t1_req2", qat(reqs, 2), 32'h8);

      $display("[TB] decode backpressure");
      resetDut(1, 1'b0);
      bus.dec_ready = 1'b0;
      repeat (10) step();
      checkOutput("bp_req_count", 32'(reqs.size()), 32'd2);
      checkOutput("bp_dec_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("bp_dec_pc",    bus.dec_pc,         32'h0);
      checkOutput("bp_dec_instr", bus.dec_instr,      32'h0050_0093);
      for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i + 3);

      $display("[TB] redirect with two fetches in flight");
      resetDut(3, 1'b0);
      waitReqs(2, 10, "rd_setup");
      checkOutput("rd_setup_rsp", 32'(bus.imem_rsp_valid), 32'd0);
      reqs.delete();
      seen_pc.delete();
      seen_instr.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      step();
      checkOutput("rd_drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
      checkOutput("rd_drain_dec_valid", 32'(bus.dec_valid),      32'd0);
      waitReqs(1, 20, "rd_req_wait");
      checkOutput("rd_first_addr", qat(reqs, 0), 32'h100);
      waitSeen(1, 20, "rd_seen_wait");
      checkOutput("rd_first_pc",    qat(seen_pc, 0),    32'h100);
      checkOutput("rd_first_instr", qat(seen_instr, 0), mem_word(32'h100));

      $display("[TB] redirect coinciding with accept and response");
      resetDut(1, 1'b0);
      waitReqs(1, 10, "co_setup");
      #1;
      checkOutput("co_setup_rsp", 32'(bus.imem_rsp_valid), 32'd1);
      checkOutput("co_setup_req", 32'(bus.imem_req_valid), 32'd1);
      reqs.delete();
      seen_pc.delete();
      seen_instr.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      checkOutput("co_wrong_path_addr", qat(reqs, 0), 32'h4);
      checkOutput("co_dec_valid",       32'(bus.dec_valid), 32'd0);
      waitReqs(2, 20, "co_req_wait");
      checkOutput("co_new_addr", qat(reqs, 1), 32'h200);
      waitSeen(1, 20, "co_seen_wait");
      checkOutput("co_first_pc",    qat(seen_pc, 0),    32'h200);
      checkOutput("co_first_instr", qat(seen_instr, 0), mem_word(32'h200));

      $display("[TB] PC wrap after redirect in START");
      resetDut(1, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      waitReqs(3, 20, "wr_req_wait");
      checkOutput("wr_req0", qat(reqs, 0), 32'hFFFF_FFF8);
      checkOutput("wr_req1", qat(reqs, 1), 32'hFFFF_FFFC);
      checkOutput("wr_req2", qat(reqs, 2), 32'h0000_0000);
      waitSeen(3, 20, "wr_seen_wait");
      checkOutput("wr_pc0", qat(seen_pc, 0), 32'hFFFF_FFF8);
      checkOutput("wr_pc2", qat(seen_pc, 2), 32'h0000_0000);

      $display("[TB] reset during drain");
      resetDut(3, 1'b0);
      waitReqs(2, 10, "rr_setup");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      step();
      #3;
      resetDut(3, 1'b1);
      waitReqs(1, 10, "rr_req_wait");
      checkOutput("rr_first_addr", qat(reqs, 0), 32'h0);
      waitSeen(1, 20, "rr_seen_wait");
      checkOutput("rr_first_pc",    qat(seen_pc, 0),    32'h0);
      checkOutput("rr_first_instr", qat(seen_instr, 0), 32'h0050_0093);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
